// File: rtl/bs_rotate_scheduler.sv
// ---------------------------------------------------------------------------
// bs_rotate_scheduler
//
// Purpose:
//   This is a multi-cycle rotate engine that two requesters share. A
//   round-robin arbiter in IDLE picks one request. The request's operand,
//   amount, direction and id are latched. The operand is then rotated by at
//   most STEP positions per RUN cycle. The result is presented on a
//   valid/ready handshake and tagged with the id of its requester.
//
// Configuration:
//   BS_SHIFT_MODE_EN  when defined, adds i_req0_shift / i_req1_shift. With
//                     shift=1 the engine performs a logical (zero-fill) shift
//                     instead of a rotate.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_reqN_valid / o_reqN_ready  request handshake for requester N (0/1)
//   i_reqN_A, i_reqN_k           operand and rotate amount (0..WIDTH-1)
//   i_reqN_left                  direction: 1=left, 0=right
//   i_reqN_shift                 (BS_SHIFT_MODE_EN only) 1=logical shift
//   o_valid / i_ready            result handshake
//   o_Y, o_id                    result and owning requester id
//   o_busy                       high whenever the engine is not idle
// ---------------------------------------------------------------------------
module bs_rotate_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KW    = $clog2(WIDTH),
    parameter int unsigned STEP  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_A,
    input  logic [KW-1:0]    i_req0_k,
    input  logic             i_req0_left,
`ifdef BS_SHIFT_MODE_EN
    input  logic             i_req0_shift,
    input  logic             i_req1_shift,
`endif
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_A,
    input  logic [KW-1:0]    i_req1_k,
    input  logic             i_req1_left,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_Y,
    output logic             o_id,
    output logic             o_busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    // Working registers
    logic [WIDTH-1:0] data_q;
    logic [KW-1:0]    rem_q;
    logic             left_q;
    logic             shift_q;
    logic             id_q;
    logic             ptr_q;     // id of the last granted requester

    // Arbitration and request selection
    logic             any_req;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [KW-1:0]    sel_k;
    logic             sel_left;
    logic             sel_shift;

    // Per-cycle rotator
    logic               last_step;
    logic [KW-1:0]      step_amt;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] dbl_sh;
    logic [WIDTH-1:0]   rot_res;
    logic [WIDTH-1:0]   lsh_res;
    logic [WIDTH-1:0]   step_res;

    // ------------------------------------------------------------------
    // Arbiter: a lone requester wins; on a tie the one not granted last wins.
    // ------------------------------------------------------------------
    always_comb begin
        any_req = i_req0_valid | i_req1_valid;
        grant   = (i_req0_valid & i_req1_valid) ? ~ptr_q : i_req1_valid;
        accept  = (state_q == StIdle) & any_req;

        sel_a    = grant ? i_req1_A    : i_req0_A;
        sel_k    = grant ? i_req1_k    : i_req0_k;
        sel_left = grant ? i_req1_left : i_req0_left;
`ifdef BS_SHIFT_MODE_EN
        sel_shift = grant ? i_req1_shift : i_req0_shift;
`else
        sel_shift = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (sel_k == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_req0_ready = (state_q == StIdle) & any_req & ~grant;
        o_req1_ready = (state_q == StIdle) & any_req & grant;
        o_valid      = (state_q == StDone);
        o_busy       = (state_q != StIdle);
    end

    assign o_Y  = data_q;
    assign o_id = id_q;

    // ------------------------------------------------------------------
    // Step rotator. The operand is doubled, so bits shifted out of one copy
    // come back in from the other, and that gives the rotate.
    // ------------------------------------------------------------------
    always_comb begin
        last_step = (rem_q <= KW'(STEP));
        step_amt  = last_step ? rem_q : KW'(STEP);
        dbl       = {data_q, data_q};
        if (left_q) begin
            dbl_sh  = dbl << step_amt;
            rot_res = dbl_sh[2*WIDTH-1:WIDTH];
            lsh_res = data_q << step_amt;
        end else begin
            dbl_sh  = dbl >> step_amt;
            rot_res = dbl_sh[WIDTH-1:0];
            lsh_res = data_q >> step_amt;
        end
        step_res = shift_q ? lsh_res : rot_res;
    end

    // ------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            shift_q <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;  // req0 wins the first tie
        end else if (accept) begin
            data_q  <= sel_a;
            rem_q   <= sel_k;
            left_q  <= sel_left;
            shift_q <= sel_shift;
            id_q    <= grant;
            ptr_q   <= grant;
        end else if (state_q == StRun) begin
            data_q <= step_res;
            rem_q  <= rem_q - step_amt;
        end
    end

endmodule
